// File: rtl/mult_div_unit_pkg.sv
// md_defs: shared MDCtr/ALUCtr encodings and default latencies for the EX stage
package md_defs;
  localparam int MD_W = 4;
  localparam logic [MD_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_W-1:0] MD_MTLO  = 4'd6;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd9;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'd10;
  localparam logic [ALU_W-1:0] ALU_LUI = 4'd11;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/opcode bus into the unit and start/busy/HI/LO back to the pipeline
// master = pipeline (drives A1, A2, MDCtr); slave = mult_div_unit (drives start, busy, HI, LO)
interface mult_div_unit_if;
  import md_defs::*;
  logic [31:0] A1;
  logic [31:0] A2;
  logic [MD_W-1:0] MDCtr;
  logic start;
  logic busy;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master(output A1, A2, MDCtr, input start, busy, HI, LO);
  modport slave(input A1, A2, MDCtr, output start, busy, HI, LO);
endinterface

// File: rtl/mult_div_unit_compute.sv
// md_compute: combinational 32x32 signed/unsigned multiply and divide producing {hi,lo}
// ports: a/b operands, op = MDCtr, res = {hi,lo}, div0 = divide op with zero divisor
module md_compute
  import md_defs::*;
(
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic [MD_W-1:0] op,
  output logic [63:0]     res,
  output logic            div0
);
  logic neg_a, neg_b;
  logic [31:0] ua, ub, ubs, uq, ur, q, r;
  logic [63:0] prod;
  // signed divide works on magnitudes; 0x80000000 stays 0x80000000 and wraps back correctly
  assign neg_a = op == MD_DIV && a[31];
  assign neg_b = op == MD_DIV && b[31];
  assign ua = neg_a ? -a : a;
  assign ub = neg_b ? -b : b;
  // a zero divisor is replaced so the divider never sees it; the result is discarded anyway
  assign ubs = ub == 32'd0 ? 32'd1 : ub;
  assign uq = ua / ubs;
  assign ur = ua % ubs;
  assign q = (neg_a ^ neg_b) ? -uq : uq;
  assign r = neg_a ? -ur : ur;
  assign prod = op == MD_MULT ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
  assign res = (op == MD_MULT || op == MD_MULTU) ? prod : {r, q};
  assign div0 = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/div with architectural HI/LO, busy for a fixed cycle count
// ports: clk, reset (sync, active-high), md (slave: A1, A2, MDCtr in; start, busy, HI, LO out)
module mult_div_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   md
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic pend_wr, is_op, is_mul, div0;
  logic [63:0] res;
  md_compute u_compute (.a(md.A1), .b(md.A2), .op(md.MDCtr), .res(res), .div0(div0));
  assign is_op = md.MDCtr >= MD_MULT && md.MDCtr <= MD_DIVU;
  assign is_mul = md.MDCtr == MD_MULT || md.MDCtr == MD_MULTU;
  assign md.busy = cnt != '0;
  assign md.start = is_op && !md.busy;
  assign md.HI = hi;
  assign md.LO = lo;
  // result is computed at accept and held; the counter only models latency
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (is_op) begin
      {pend_hi, pend_lo} <= res;
      pend_wr <= !div0;
      cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (md.MDCtr == MD_MTHI) begin
      hi <= md.A1;
    end else if (md.MDCtr == MD_MTLO) begin
      lo <= md.A1;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import md_defs::*;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  mult_div_unit_if md ();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [MD_W-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    md.A1 = a;
    md.A2 = b;
    md.MDCtr = op;
    #1;
    chk({tag, " start"}, 32'(md.start), 32'd1);
    tick();
    md.MDCtr = MD_NONE;
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"}, 32'(md.busy), 32'd1);
      tick();
    end
    chk({tag, " idle"}, 32'(md.busy), 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    md.A1 = '0;
    md.A2 = '0;
    md.MDCtr = MD_NONE;
    tick();
    tick();
    reset = 1'b0;
    chk("rst busy", 32'(md.busy), 32'd0);
    chk("rst hi", md.HI, 32'd0);
    chk("rst lo", md.LO, 32'd0);
    run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 5);
    chk("mult hi", md.HI, 32'hFFFFFFFF);
    chk("mult lo", md.LO, 32'hFFFFFFFE);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5);
    chk("multu hi", md.HI, 32'h00000001);
    chk("multu lo", md.LO, 32'hFFFFFFFE);
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
    chk("div hi", md.HI, 32'hFFFFFFFF);
    chk("div lo", md.LO, 32'hFFFFFFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd3, 10);
    chk("divu hi", md.HI, 32'd1);
    chk("divu lo", md.LO, 32'd2);
    run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10);
    chk("divu0 hi", md.HI, 32'd1);
    chk("divu0 lo", md.LO, 32'd2);
    md.MDCtr = 4'd7;
    md.A1 = 32'h55555555;
    #1;
    chk("op7 start", 32'(md.start), 32'd0);
    tick();
    chk("op7 busy", 32'(md.busy), 32'd0);
    chk("op7 hi", md.HI, 32'd1);
    md.MDCtr = MD_MTHI;
    md.A1 = 32'h12345678;
    #1;
    chk("mthi start", 32'(md.start), 32'd0);
    tick();
    chk("mthi busy", 32'(md.busy), 32'd0);
    chk("mthi hi", md.HI, 32'h12345678);
    md.MDCtr = MD_MTLO;
    md.A1 = 32'h9ABCDEF0;
    tick();
    chk("mtlo busy", 32'(md.busy), 32'd0);
    chk("mtlo lo", md.LO, 32'h9ABCDEF0);
    chk("mtlo hi", md.HI, 32'h12345678);
    md.MDCtr = MD_MULT;
    md.A1 = 32'd3;
    md.A2 = 32'd4;
    tick();
    md.MDCtr = MD_MTHI;
    md.A1 = 32'hDEADBEEF;
    #1;
    chk("ign start", 32'(md.start), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ign busy", 32'(md.busy), 32'd1);
      tick();
    end
    md.MDCtr = MD_NONE;
    chk("ign idle", 32'(md.busy), 32'd0);
    chk("ign hi", md.HI, 32'd0);
    chk("ign lo", md.LO, 32'd12);
    run_op("divmin", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("divmin hi", md.HI, 32'd0);
    chk("divmin lo", md.LO, 32'h80000000);
    md.MDCtr = MD_MTHI;
    md.A1 = 32'hCAFEF00D;
    tick();
    chk("pre hi", md.HI, 32'hCAFEF00D);
    md.MDCtr = MD_DIV;
    md.A1 = 32'h80000000;
    md.A2 = 32'hFFFFFFFF;
    tick();
    md.MDCtr = MD_NONE;
    tick();
    tick();
    tick();
    chk("abort busy4", 32'(md.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 32'(md.busy), 32'd0);
    chk("abort hi", md.HI, 32'd0);
    chk("abort lo", md.LO, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort busy10", 32'(md.busy), 32'd0);
    chk("abort hi10", md.HI, 32'd0);
    chk("abort lo10", md.LO, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the single-cycle ALU and shares the same operand buses A1/A2 from the ID/EX register.
- Serves MIPS mult, multu, div, divu, mthi and mtlo. mfhi/mflo read HI/LO directly.
- Hazard logic stalls ID while `start` or `busy` is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- A1  in  32  rs operand (dividend / multiplicand / mthi/mtlo source).
- A2  in  32  rt operand (divisor / multiplier).
- MDCtr  in  4  operation code; 0 = none.
- start  out  1  combinational: MDCtr is mult/multu/div/divu this cycle.
- busy  out  1  registered: operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- MDCtr encoding:
  - 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo.
  - 0111–1111 are treated as none.
- Reset, checked first every edge:
  - HI=0, LO=0, busy=0, cnt=0, pending result cleared.
  - Reset mid-operation aborts it; no HI/LO write occurs.
- States:
  - IDLE (cnt==0).
  - RUN (cnt!=0). busy = (cnt!=0), a registered count, not decoded combinationally.
- Accept (IDLE only): on the edge where MDCtr is mult/multu/div/divu:
  - latch the 64-bit result {hi,lo} computed from A1/A2 into pending registers;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - the next cycle, busy=1.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1, HI/LO take the pending values and cnt→0.
  - busy is therefore high for exactly N cycles after the accept edge; new HI/LO are visible in the first cycle busy is low.
- While busy:
  - any MDCtr value, including mthi/mtlo and new start, is ignored; HI/LO are not modified.
  - The stall logic guarantees this does not occur in a correct pipeline; the bench checks the ignore.
- mthi/mtlo (IDLE only): on the edge, HI←A1 (mthi) or LO←A1 (mtlo). Zero latency, busy stays 0.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (A2==0, div or divu): the operation runs its full DIV_CYCLES with busy; HI/LO are left unchanged at completion.
- start = (MDCtr in {0001..0100}) && !busy.
  - Combinational, so the stall unit sees the accept cycle before busy rises.
- Back-to-back: a new op may be accepted in the same cycle busy first reads 0, i.e. the edge that ends the prior op has already written HI/LO.

Decomposition:
- Shared package (md_defs): MDCtr encodings MD_NONE..MD_MTLO, MULT_CYCLES/DIV_CYCLES defaults, MDCtr width constant. The ALUCtr encodings move into the same package file.
- One natural sub-module: md_compute.
  - Purely combinational; inputs A1, A2, op; outputs 64-bit {hi,lo} and a div0 flag.
  - Isolates the signed/unsigned multiply/divide and sign fix-ups from the counter/state logic in mult_div_unit.

Test Plan:
- Reset then mult, A1=0xFFFFFFFF, A2=2 → busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A1=0xFFFFFFF9 (−7), A2=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A1=7, A2=3 → LO=2, HI=1. Then divu A2=0 → busy 10 cycles, HI=1 and LO=2 unchanged.
- mthi A1=0x12345678, next cycle mtlo A1=0x9ABCDEF0 → HI/LO updated next edge, busy never asserts. Then mult start followed by mthi while busy → mthi ignored, HI equals the mult result.
- Start div 0x80000000 / 0xFFFFFFFF, assert reset on the 4th busy cycle → next cycle busy=0, HI=LO=0, and they remain 0 after 10 more cycles.
